// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the frame controller, the uart_rx byte receiver and
// the frame consumer. The slave view belongs to uart_rx_frame_ctrl; the
// master view drives it (byte source plus consumer).
interface uart_rx_frame_ctrl_if;
  logic       Rx_Done_Sig;
  logic [7:0] Rx_Data;
  logic       Rx_En_Sig;
  logic       Frame_Ready;
  logic [7:0] Frame_Len;
  logic [7:0] Rd_Addr;
  logic [7:0] Rd_Data;
  logic       Frame_Ack;
  logic       Frame_Err;
  logic [1:0] Err_Code;

  modport slave (
    input  Rx_Done_Sig, Rx_Data, Rd_Addr, Frame_Ack,
    output Rx_En_Sig, Frame_Ready, Frame_Len, Rd_Data, Frame_Err, Err_Code
  );

  modport master (
    output Rx_Done_Sig, Rx_Data, Rd_Addr, Frame_Ack,
    input  Rx_En_Sig, Frame_Ready, Frame_Len, Rd_Data, Frame_Err, Err_Code
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame assembler behind uart_rx. Hunts for HDR_BYTE, takes a length byte,
// stores the payload and checks an 8-bit running sum over LEN+payload.
// A good frame is held in the buffer until Frame_Ack; bad length, bad sum or
// an inter-byte stall drops the frame with a one-cycle Frame_Err pulse.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input logic                  CLK,
  input logic                  RST_n,
  uart_rx_frame_ctrl_if.slave  bus
);

  localparam int unsigned   AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned   TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_DATA, S_SUM, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    code_q, code_d;
  logic          err_q, err_d;
  logic          rx_en_q;
  logic          buf_we;
  logic [7:0]    frame_buf [MAX_LEN];

  // Next-state, datapath updates and error decisions for one received byte
  // or one idle cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    code_d  = code_q;
    err_d   = 1'b0;
    buf_we  = 1'b0;

    case (state_q)
      S_HUNT: begin
        tmo_d = '0;
        if (bus.Rx_Done_Sig && bus.Rx_Data == HDR_BYTE) state_d = S_LEN;
      end

      S_LEN, S_DATA, S_SUM: begin
        if (bus.Rx_Done_Sig) begin
          // A byte always beats a coincident timeout.
          tmo_d = '0;
          case (state_q)
            S_LEN: begin
              if (bus.Rx_Data != 8'd0 && {1'b0, bus.Rx_Data} <= MAX_LEN_W) begin
                len_d   = bus.Rx_Data;
                sum_d   = bus.Rx_Data;
                idx_d   = 8'd0;
                state_d = S_DATA;
              end else begin
                err_d   = 1'b1;
                code_d  = 2'd1;
                state_d = S_HUNT;
              end
            end
            S_DATA: begin
              buf_we = 1'b1;
              sum_d  = sum_q + bus.Rx_Data;
              idx_d  = idx_q + 8'd1;
              if (idx_q == len_q - 8'd1) state_d = S_SUM;
            end
            default: begin
              if (bus.Rx_Data == sum_q) begin
                state_d = S_HOLD;
              end else begin
                err_d   = 1'b1;
                code_d  = 2'd2;
                state_d = S_HUNT;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = S_HUNT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_HOLD: begin
        if (bus.Frame_Ack) state_d = S_HUNT;
      end

      default: state_d = S_HUNT;
    endcase
  end

  // Control and status registers; receiver enable drops for the cycle after
  // each byte and for the whole time a frame is held.
  always_ff @(posedge CLK or negedge RST_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before this edge, independent of statement order.
    if (!RST_n) begin
      state_q <= S_HUNT;
      len_q   <= 8'd0;
      sum_q   <= 8'd0;
      idx_q   <= 8'd0;
      tmo_q   <= '0;
      code_q  <= 2'd0;
      err_q   <= 1'b0;
      rx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      err_q   <= err_d;
      rx_en_q <= (state_d != S_HOLD) && !bus.Rx_Done_Sig;
    end
  end

  // Payload store, written one byte per DATA-phase byte.
  always_ff @(posedge CLK) begin
    // NOTE: the buffer has no reset; its contents are only read under
    // Frame_Ready, which keeps it mappable onto plain RAM.
    if (buf_we) frame_buf[idx_q[AW-1:0]] <= bus.Rx_Data;
  end

  // Combinational buffer read; addresses beyond the buffer read as zero.
  always_comb begin
    bus.Rd_Data = 8'h00;
    if ({1'b0, bus.Rd_Addr} < MAX_LEN_W) bus.Rd_Data = frame_buf[bus.Rd_Addr[AW-1:0]];
  end

  assign bus.Rx_En_Sig   = rx_en_q;
  assign bus.Frame_Ready = (state_q == S_HOLD);
  assign bus.Frame_Len   = len_q;
  assign bus.Frame_Err   = err_q;
  assign bus.Err_Code    = code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed scenarios plus a
// randomized run scored against a frame-parsing reference model.
module tb_uart_rx_frame_ctrl;
  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 200;
  localparam logic [7:0] HDR     = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  uart_rx_frame_ctrl_if bus();

  uart_rx_frame_ctrl #(.HDR_BYTE(HDR), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  int         total = 0;
  int         passed = 0;
  int         err_seen = 0;
  int         width_viol = 0;
  int         en_viol = 0;
  logic [1:0] code_seen = 2'd0;
  logic [1:0] exp_code = 2'd0;
  bit         prev_err = 1'b0;
  bit         prev_done = 1'b0;

  // Passive monitor: counts error pulses, pulse width and the enable gap.
  always @(negedge CLK) begin
    if (!RST_n) begin
      prev_err  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.Frame_Err) begin
        err_seen++;
        code_seen = bus.Err_Code;
        if (prev_err) width_viol++;
      end
      if (prev_done && bus.Rx_En_Sig) en_viol++;
      prev_err  = bus.Frame_Err;
      prev_done = bus.Rx_Done_Sig;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Deliver one byte as a uart_rx done pulse; optionally wait for the enable.
  task automatic send_byte(input logic [7:0] b, input bit wait_en);
    int n;
    repeat ($urandom_range(0, 3)) tick();
    n = 0;
    if (wait_en) begin
      while (!bus.Rx_En_Sig && n < 20) begin
        tick();
        n++;
      end
      if (!bus.Rx_En_Sig) begin
        total++;
        $display("FAIL rx_en_wait: Rx_En_Sig still %b after %0d cycles, want 1", bus.Rx_En_Sig, n);
      end
    end
    bus.Rx_Data     = b;
    bus.Rx_Done_Sig = 1'b1;
    tick();
    bus.Rx_Done_Sig = 1'b0;
  endtask

  task automatic send_seq(input bq_t s, input bit wait_en);
    foreach (s[i]) send_byte(s[i], wait_en);
  endtask

  task automatic pulse_ack();
    bus.Frame_Ack = 1'b1;
    tick();
    bus.Frame_Ack = 1'b0;
  endtask

  // Reference: scan the byte stream for frames. Unknown bytes are skipped,
  // a bad length drops header+len, a bad sum drops the whole frame, and the
  // first good frame ends the scan.
  task automatic model(input bq_t s, output int n_err, output logic [1:0] code,
                       output bit good, output bq_t pay);
    int i;
    int len;
    int sum;
    n_err = 0;
    code  = 2'd0;
    good  = 1'b0;
    pay   = {};
    i = 0;
    while (i < s.size() && !good) begin
      if (s[i] != HDR) begin
        i++;
      end else if (i + 1 >= s.size()) begin
        break;
      end else begin
        len = int'(s[i+1]);
        if (len == 0 || len > MAX_LEN) begin
          n_err++;
          code = 2'd1;
          i += 2;
        end else if (i + 2 + len >= s.size()) begin
          break;
        end else begin
          sum = 0;
          for (int k = 0; k <= len; k++) sum += int'(s[i+1+k]);
          if (int'(s[i+2+len]) == sum % 256) begin
            good = 1'b1;
            for (int k = 0; k < len; k++) pay.push_back(s[i+2+k]);
          end else begin
            n_err++;
            code = 2'd2;
            i += 3 + len;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.Rx_Done_Sig = 1'b0;
    bus.Rx_Data     = 8'h00;
    bus.Rd_Addr     = 8'h00;
    bus.Frame_Ack   = 1'b0;
    RST_n = 1'b0;
    repeat (3) tick();
    total++; if (bus.Frame_Ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.Frame_Ready); else passed++;
    total++; if (bus.Frame_Len !== 8'd0) $display("FAIL rst_len: got %h want 00", bus.Frame_Len); else passed++;
    total++; if (bus.Frame_Err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.Frame_Err); else passed++;
    total++; if (bus.Err_Code !== 2'd0) $display("FAIL rst_code: got %0d want 0", bus.Err_Code); else passed++;
    total++; if (bus.Rx_En_Sig !== 1'b0) $display("FAIL rst_en: got %b want 0", bus.Rx_En_Sig); else passed++;
    @(negedge CLK);
    RST_n = 1'b1;
    #1;
    total++; if (bus.Rx_En_Sig !== 1'b0) $display("FAIL rst_en_release: got %b want 0", bus.Rx_En_Sig); else passed++;
    tick();
    total++; if (bus.Rx_En_Sig !== 1'b1) $display("FAIL rst_en_first: got %b want 1", bus.Rx_En_Sig); else passed++;
  endtask

  task automatic test_good_frame();
    logic [7:0] exp_pay [3] = '{8'h11, 8'h22, 8'h33};
    int e0 = err_seen;
    send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 1'b1);
    repeat (2) tick();
    total++; if (bus.Frame_Ready !== 1'b1) $display("FAIL good_ready: got %b want 1", bus.Frame_Ready); else passed++;
    total++; if (bus.Frame_Len !== 8'd3) $display("FAIL good_len: got %h want 03", bus.Frame_Len); else passed++;
    total++; if (bus.Rx_En_Sig !== 1'b0) $display("FAIL good_en_hold: got %b want 0", bus.Rx_En_Sig); else passed++;
    total++; if (err_seen - e0 !== 0) $display("FAIL good_no_err: got %0d pulses want 0", err_seen - e0); else passed++;
    for (int i = 0; i < 3; i++) begin
      bus.Rd_Addr = 8'(i);
      tick();
      total++; if (bus.Rd_Data !== exp_pay[i]) $display("FAIL good_data[%0d]: got %h want %h", i, bus.Rd_Data, exp_pay[i]); else passed++;
    end
    pulse_ack();
    total++; if (bus.Frame_Ready !== 1'b0) $display("FAIL good_ack_ready: got %b want 0", bus.Frame_Ready); else passed++;
    total++; if (bus.Rx_En_Sig !== 1'b1) $display("FAIL good_ack_en: got %b want 1", bus.Rx_En_Sig); else passed++;
  endtask

  task automatic test_bad_sum();
    int e0 = err_seen;
    send_seq('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}, 1'b1);
    repeat (2) tick();
    exp_code = 2'd2;
    total++; if (err_seen - e0 !== 1) $display("FAIL sum_pulses: got %0d want 1", err_seen - e0); else passed++;
    total++; if (bus.Err_Code !== exp_code) $display("FAIL sum_code: got %0d want 2", bus.Err_Code); else passed++;
    total++; if (bus.Frame_Ready !== 1'b0) $display("FAIL sum_ready: got %b want 0", bus.Frame_Ready); else passed++;
    total++; if (bus.Frame_Len !== 8'd2) $display("FAIL sum_len_hold: got %h want 02", bus.Frame_Len); else passed++;
  endtask

  task automatic test_bad_len();
    logic [7:0] lens [2] = '{8'h00, 8'h11};
    foreach (lens[j]) begin
      int e0 = err_seen;
      send_seq('{HDR, lens[j]}, 1'b1);
      repeat (2) tick();
      exp_code = 2'd1;
      total++; if (err_seen - e0 !== 1) $display("FAIL len_pulses(%h): got %0d want 1", lens[j], err_seen - e0); else passed++;
      total++; if (bus.Err_Code !== exp_code) $display("FAIL len_code(%h): got %0d want 1", lens[j], bus.Err_Code); else passed++;
      total++; if (bus.Frame_Len !== 8'd2) $display("FAIL len_len_hold(%h): got %h want 02", lens[j], bus.Frame_Len); else passed++;
      total++; if (bus.Rx_En_Sig !== 1'b1) $display("FAIL len_hunt_en(%h): got %b want 1", lens[j], bus.Rx_En_Sig); else passed++;
    end
  endtask

  // Leaves the one-byte frame held for test_hold.
  task automatic test_junk_then_good();
    logic [7:0] far_addr [2] = '{8'd16, 8'd255};
    int e0 = err_seen;
    send_seq('{8'hFF, 8'h00, 8'hA5, 8'h01, 8'h7F, 8'h80}, 1'b1);
    repeat (2) tick();
    total++; if (err_seen - e0 !== 0) $display("FAIL junk_no_err: got %0d pulses want 0", err_seen - e0); else passed++;
    total++; if (bus.Frame_Ready !== 1'b1) $display("FAIL junk_ready: got %b want 1", bus.Frame_Ready); else passed++;
    total++; if (bus.Frame_Len !== 8'd1) $display("FAIL junk_len: got %h want 01", bus.Frame_Len); else passed++;
    bus.Rd_Addr = 8'd0;
    tick();
    total++; if (bus.Rd_Data !== 8'h7F) $display("FAIL junk_data0: got %h want 7f", bus.Rd_Data); else passed++;
    foreach (far_addr[j]) begin
      bus.Rd_Addr = far_addr[j];
      tick();
      total++; if (bus.Rd_Data !== 8'h00) $display("FAIL rd_oob(%0d): got %h want 00", far_addr[j], bus.Rd_Data); else passed++;
    end
  endtask

  task automatic test_hold();
    int e0 = err_seen;
    send_seq('{8'hA5, 8'h01, 8'h55, 8'h56}, 1'b0);
    repeat (2) tick();
    bus.Rd_Addr = 8'd0;
    tick();
    total++; if (err_seen - e0 !== 0) $display("FAIL hold_no_err: got %0d pulses want 0", err_seen - e0); else passed++;
    total++; if (bus.Frame_Ready !== 1'b1) $display("FAIL hold_ready: got %b want 1", bus.Frame_Ready); else passed++;
    total++; if (bus.Rx_En_Sig !== 1'b0) $display("FAIL hold_en: got %b want 0", bus.Rx_En_Sig); else passed++;
    total++; if (bus.Rd_Data !== 8'h7F) $display("FAIL hold_data0: got %h want 7f", bus.Rd_Data); else passed++;
    total++; if (bus.Frame_Len !== 8'd1) $display("FAIL hold_len: got %h want 01", bus.Frame_Len); else passed++;
    pulse_ack();
    total++; if (bus.Frame_Ready !== 1'b0) $display("FAIL hold_ack_ready: got %b want 0", bus.Frame_Ready); else passed++;
    total++; if (bus.Rx_En_Sig !== 1'b1) $display("FAIL hold_ack_en: got %b want 1", bus.Rx_En_Sig); else passed++;
  endtask

  task automatic test_ack_outside_hold();
    int e0 = err_seen;
    pulse_ack();
    send_seq('{8'hA5, 8'h02, 8'h01}, 1'b1);
    pulse_ack();
    send_seq('{8'h02, 8'h05}, 1'b1);
    repeat (2) tick();
    total++; if (err_seen - e0 !== 0) $display("FAIL stray_ack_no_err: got %0d pulses want 0", err_seen - e0); else passed++;
    total++; if (bus.Frame_Ready !== 1'b1) $display("FAIL stray_ack_ready: got %b want 1", bus.Frame_Ready); else passed++;
    total++; if (bus.Frame_Len !== 8'd2) $display("FAIL stray_ack_len: got %h want 02", bus.Frame_Len); else passed++;
    pulse_ack();
  endtask

  task automatic test_timeout();
    int e0 = err_seen;
    int first = -1;
    send_seq('{8'hA5, 8'h04, 8'h01}, 1'b1);
    for (int k = 1; k <= TMO + 6; k++) begin
      @(negedge CLK);
      if (bus.Frame_Err && first < 0) first = k;
    end
    tick();
    exp_code = 2'd3;
    total++; if (!(first >= TMO - 2 && first <= TMO + 3)) $display("FAIL tmo_latency: got %0d cycles want about %0d", first, TMO); else passed++;
    total++; if (err_seen - e0 !== 1) $display("FAIL tmo_pulses: got %0d want 1", err_seen - e0); else passed++;
    total++; if (bus.Err_Code !== exp_code) $display("FAIL tmo_code: got %0d want 3", bus.Err_Code); else passed++;
    total++; if (bus.Frame_Len !== 8'd4) $display("FAIL tmo_len_hold: got %h want 04", bus.Frame_Len); else passed++;
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h01}, 1'b1);
    repeat (2) tick();
    bus.Rd_Addr = 8'd0;
    tick();
    total++; if (bus.Frame_Ready !== 1'b1) $display("FAIL tmo_next_ready: got %b want 1", bus.Frame_Ready); else passed++;
    total++; if (bus.Rd_Data !== 8'h00) $display("FAIL tmo_next_data0: got %h want 00", bus.Rd_Data); else passed++;
    pulse_ack();
  endtask

  task automatic test_reset_mid_frame();
    send_seq('{8'hA5, 8'h05, 8'h01, 8'h02}, 1'b1);
    RST_n = 1'b0;
    #1;
    exp_code = 2'd0;
    total++; if (bus.Frame_Len !== 8'd0) $display("FAIL midrst_len: got %h want 00", bus.Frame_Len); else passed++;
    total++; if (bus.Err_Code !== exp_code) $display("FAIL midrst_code: got %0d want 0", bus.Err_Code); else passed++;
    total++; if (bus.Rx_En_Sig !== 1'b0) $display("FAIL midrst_en: got %b want 0", bus.Rx_En_Sig); else passed++;
    tick();
    @(negedge CLK);
    RST_n = 1'b1;
    tick();
    send_seq('{8'hA5, 8'h01, 8'hAA, 8'hAB}, 1'b1);
    repeat (2) tick();
    total++; if (bus.Frame_Ready !== 1'b1) $display("FAIL midrst_next_ready: got %b want 1", bus.Frame_Ready); else passed++;
    total++; if (bus.Frame_Len !== 8'd1) $display("FAIL midrst_next_len: got %h want 01", bus.Frame_Len); else passed++;
    pulse_ack();
  endtask

  // Random junk, an optional bad frame, then a good frame, scored by model().
  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      bq_t s, pay;
      int n_err, e0, len, sum, kind;
      logic [1:0] m_code;
      bit good;
      logic [7:0] b;
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == HDR) b = 8'h5A;
        s.push_back(b);
      end
      kind = $urandom_range(0, 2);
      if (kind == 1) begin
        s.push_back(HDR);
        s.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else if (kind == 2) begin
        len = $urandom_range(1, MAX_LEN);
        s.push_back(HDR);
        s.push_back(8'(len));
        sum = len;
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          sum += int'(b);
          s.push_back(b);
        end
        s.push_back(8'((sum + $urandom_range(1, 255)) % 256));
      end
      len = $urandom_range(1, MAX_LEN);
      s.push_back(HDR);
      s.push_back(8'(len));
      sum = len;
      for (int k = 0; k < len; k++) begin
        b = ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom_range(0, 255));
        sum += int'(b);
        s.push_back(b);
      end
      s.push_back(8'(sum % 256));

      model(s, n_err, m_code, good, pay);
      if (n_err > 0) exp_code = m_code;
      e0 = err_seen;
      send_seq(s, 1'b1);
      repeat (2) tick();
      total++; if (err_seen - e0 !== n_err) $display("FAIL rnd%0d_pulses: got %0d want %0d", it, err_seen - e0, n_err); else passed++;
      total++; if (bus.Err_Code !== exp_code) $display("FAIL rnd%0d_code: got %0d want %0d", it, bus.Err_Code, exp_code); else passed++;
      total++; if (bus.Frame_Ready !== good) $display("FAIL rnd%0d_ready: got %b want %b", it, bus.Frame_Ready, good); else passed++;
      total++; if (bus.Frame_Len !== 8'(pay.size())) $display("FAIL rnd%0d_len: got %0d want %0d", it, bus.Frame_Len, pay.size()); else passed++;
      foreach (pay[k]) begin
        bus.Rd_Addr = 8'(k);
        tick();
        total++; if (bus.Rd_Data !== pay[k]) $display("FAIL rnd%0d_data[%0d]: got %h want %h", it, k, bus.Rd_Data, pay[k]); else passed++;
      end
      pulse_ack();
      total++; if (bus.Frame_Ready !== 1'b0) $display("FAIL rnd%0d_ack: got %b want 0", it, bus.Frame_Ready); else passed++;
    end
  endtask

  task automatic test_protocol_monitors();
    total++; if (width_viol !== 0) $display("FAIL err_width: got %0d wide pulses want 0", width_viol); else passed++;
    total++; if (en_viol !== 0) $display("FAIL en_gap: got %0d cycles enabled after a byte want 0", en_viol); else passed++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_sum();
    test_bad_len();
    test_junk_then_good();
    test_hold();
    test_ack_outside_hold();
    test_timeout();
    test_reset_mid_frame();
    test_random(30);
    test_protocol_monitors();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, total);
    $fatal(1);
  end

endmodule
